mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit resource port (e.g. data-memory port) between four requesters.
- Drives the 2-bit select of the 4:1 32-bit operand/address mux feeding that port, plus one-hot grants back to the requesters.
- Holds a grant for a whole transaction, ended by a completion strobe from the resource.
- A watchdog aborts transactions that never complete.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without mem_done before abort. Legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the watchdog counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per requester; bit i = requester i, level-sensitive
- mem_done  input  1  one-cycle completion strobe from the shared resource
- sel  output  2  select for the 4:1 mux: 2'b00→d00, 01→d01, 10→d10, 11→d11
- gnt  output  4  one-hot grant, all-zero when idle
- mem_start  output  1  one-cycle pulse in the first BUSY cycle
- busy  output  1  high while in BUSY
- timeout_err  output  1  sticky; set on watchdog abort

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Ports are clk and rst_n.

Behaviour:
- Reset (rst_n=0, async):
  - State = IDLE; sel=2'b00; gnt=4'b0000; mem_start=0; busy=0; timeout_err=0.
  - Watchdog count = 0; last_grant pointer = 2'd3, so the first arbitration favours requester 0.
- States: IDLE, BUSY. All outputs are registered.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise pick the winner: the first asserted req bit scanning from last_grant+1 upward, modulo 4.
  - Next edge: sel=winner, gnt=onehot(winner), busy=1, mem_start=1, count=0, state=BUSY.
- Latency: req high before edge N → gnt/sel/mem_start valid after edge N (one cycle).
- BUSY:
  - mem_start is high only in the first BUSY cycle.
  - sel and gnt are held constant for the whole transaction.
  - Dropping req during BUSY is ignored: the transaction is committed.
  - On mem_done=1, next edge: gnt=0, busy=0, last_grant=sel, state=IDLE. sel keeps its last value.
  - If count reaches TIMEOUT_CYCLES-1 with no mem_done, next edge: same exit as mem_done, plus timeout_err=1.
  - Otherwise count increments by 1; it saturates and never wraps.
  - mem_done and timeout in the same cycle: treated as normal completion, timeout_err not set.
- mem_done while in IDLE: ignored, no state change.
- Fairness and bubbles:
  - There is exactly one IDLE cycle between consecutive transactions.
  - A requester holding req continuously is granted at most once every 4 transactions when all four request.
  - Only the pointer update decides rotation; there is no fixed priority.
- timeout_err is cleared only by rst_n.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronously). No mem_start is issued until rst_n deasserts and a req is sampled.
- Invariants:
  - gnt is one-hot or zero.
  - When gnt≠0, gnt == onehot(sel).
  - busy == (gnt≠0).

Test Plan:
- Reset then req=4'b0100 for 1 cycle → next cycle sel=2'b10, gnt=4'b0100, mem_start=1, busy=1; mem_done 3 cycles later → gnt=0, busy=0 on the following edge.
- req=4'b1111 held, mem_done 2 cycles after each mem_start → grant order 0,1,2,3,0; one IDLE cycle between grants; mem_start count = 5.
- req=4'b1001 after grant to 3 completes (last_grant=3) → next grant is requester 0 (sel=00), then requester 3.
- TIMEOUT_CYCLES=4, req=4'b0010, no mem_done → gnt=4'b0010 for exactly 4 cycles, then busy=0, timeout_err=1 and stays 1 through 2 further transactions.
- Grant to requester 1, drop req next cycle, mem_done 5 cycles later → gnt held at 4'b0010 until the mem_done edge; mem_done pulsed in IDLE → no change.
- rst_n pulsed low mid-BUSY (gnt=4'b1000) → gnt=0, sel=00, busy=0 before the next clk edge; after release with req=4'b1000 → requester 3 granted.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/grant and resource-handshake bundle for the round-robin arbiter.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic       mem_done;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       mem_start;
    logic       busy;
    logic       timeout_err;
    modport master (input req, mem_done, output sel, gnt, mem_start, busy, timeout_err);
    modport slave (output req, mem_done, input sel, gnt, mem_start, busy, timeout_err);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one resource port among four requesters,
// holding each grant until mem_done or a watchdog abort.
module mux4_rr_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    mux4_rr_arbiter_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state, state_nxt;
    logic [1:0] sel_q, sel_nxt, last, last_nxt, win, off;
    logic [3:0] gnt_q, gnt_nxt, rot;
    logic start_q, start_nxt, busy_q, busy_nxt, err_q, err_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Rotate requests so bit 0 is the requester right after the last winner.
    always_comb begin
        rot = 4'({bus.req, bus.req} >> ({1'b0, last} + 3'd1));
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        win = last + 2'd1 + off;
    end

    always_comb begin
        state_nxt = state;
        sel_nxt = sel_q;
        gnt_nxt = gnt_q;
        start_nxt = 1'b0;
        busy_nxt = busy_q;
        err_nxt = err_q;
        cnt_nxt = cnt;
        last_nxt = last;
        if (state == IDLE) begin
            if (|bus.req) begin
                state_nxt = BUSY;
                sel_nxt = win;
                gnt_nxt = 4'b0001 << win;
                start_nxt = 1'b1;
                busy_nxt = 1'b1;
                cnt_nxt = '0;
            end
        end else if (bus.mem_done || cnt == LIMIT) begin
            state_nxt = IDLE;
            gnt_nxt = 4'b0000;
            busy_nxt = 1'b0;
            last_nxt = sel_q;
            err_nxt = err_q | ~bus.mem_done;
        end else begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= 2'b00;
            gnt_q <= 4'b0000;
            start_q <= 1'b0;
            busy_q <= 1'b0;
            err_q <= 1'b0;
            cnt <= '0;
            last <= 2'd3;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
            gnt_q <= gnt_nxt;
            start_q <= start_nxt;
            busy_q <= busy_nxt;
            err_q <= err_nxt;
            cnt <= cnt_nxt;
            last <= last_nxt;
        end
    end

    assign bus.sel = sel_q;
    assign bus.gnt = gnt_q;
    assign bus.mem_start = start_q;
    assign bus.busy = busy_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed checks of arbitration order, hold, watchdog and async reset.
module tb_mux4_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int starts = 0;

    mux4_rr_arbiter_if a ();
    mux4_rr_arbiter_if t ();

    mux4_rr_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(a));
    mux4_rr_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_t (.clk(clk), .rst_n(rst_n), .bus(t));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        starts += int'(a.mem_start);
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        a.req = 4'b0000;
        a.mem_done = 1'b0;
        t.req = 4'b0000;
        t.mem_done = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset;
        vectors++;
        if ({a.sel, a.gnt, a.mem_start, a.busy, a.timeout_err} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b", {a.sel, a.gnt, a.mem_start, a.busy, a.timeout_err}, 9'b0);
        end
        vectors++;
        if ({t.gnt, t.busy, t.timeout_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs_t: got %b expected %b", {t.gnt, t.busy, t.timeout_err}, 6'b0);
        end
    endtask

    task automatic test_single;
        apply_reset;
        a.req = 4'b0100;
        tick;
        a.req = 4'b0000;
        vectors++;
        if ({a.sel, a.gnt, a.mem_start, a.busy} !== {2'b10, 4'b0100, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL single_grant: got %b expected %b", {a.sel, a.gnt, a.mem_start, a.busy}, {2'b10, 4'b0100, 1'b1, 1'b1});
        end
        tick;
        vectors++;
        if ({a.gnt, a.mem_start} !== {4'b0100, 1'b0}) begin
            miscompares++;
            $display("FAIL single_start_pulse: got %b expected %b", {a.gnt, a.mem_start}, {4'b0100, 1'b0});
        end
        tick;
        a.mem_done = 1'b1;
        tick;
        a.mem_done = 1'b0;
        vectors++;
        if ({a.sel, a.gnt, a.busy} !== {2'b10, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL single_release: got %b expected %b", {a.sel, a.gnt, a.busy}, {2'b10, 4'b0000, 1'b0});
        end
    endtask

    task automatic test_rotation;
        apply_reset;
        starts = 0;
        a.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick;
            vectors++;
            if (a.sel !== 2'(i % 4) || a.gnt !== 4'(4'b0001 << (i % 4)) || a.mem_start !== 1'b1) begin
                miscompares++;
                $display("FAIL rotation_grant%0d: got sel=%0d gnt=%b start=%b expected sel=%0d", i, a.sel, a.gnt, a.mem_start, i % 4);
            end
            tick;
            a.mem_done = 1'b1;
            tick;
            a.mem_done = 1'b0;
            vectors++;
            if ({a.gnt, a.busy} !== 5'b0) begin
                miscompares++;
                $display("FAIL rotation_bubble%0d: got gnt=%b busy=%b expected idle", i, a.gnt, a.busy);
            end
        end
        a.req = 4'b0000;
        tick;
        vectors++;
        if (starts !== 5) begin
            miscompares++;
            $display("FAIL rotation_starts: got %0d expected 5", starts);
        end
    endtask

    task automatic test_wrap;
        apply_reset;
        a.req = 4'b1000;
        tick;
        a.req = 4'b0000;
        a.mem_done = 1'b1;
        tick;
        a.mem_done = 1'b0;
        a.req = 4'b1001;
        tick;
        vectors++;
        if ({a.sel, a.gnt} !== {2'b00, 4'b0001}) begin
            miscompares++;
            $display("FAIL wrap_first: got %b expected %b", {a.sel, a.gnt}, {2'b00, 4'b0001});
        end
        a.mem_done = 1'b1;
        tick;
        a.mem_done = 1'b0;
        tick;
        vectors++;
        if ({a.sel, a.gnt} !== {2'b11, 4'b1000}) begin
            miscompares++;
            $display("FAIL wrap_second: got %b expected %b", {a.sel, a.gnt}, {2'b11, 4'b1000});
        end
        a.req = 4'b0000;
        a.mem_done = 1'b1;
        tick;
        a.mem_done = 1'b0;
    endtask

    task automatic test_timeout;
        apply_reset;
        t.req = 4'b0100;
        tick;
        t.req = 4'b0000;
        tick;
        tick;
        tick;
        t.mem_done = 1'b1;
        tick;
        t.mem_done = 1'b0;
        vectors++;
        if ({t.busy, t.timeout_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_tie: got busy=%b err=%b expected 0 0", t.busy, t.timeout_err);
        end
        t.req = 4'b0010;
        tick;
        t.req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (t.gnt !== 4'b0010 || t.timeout_err !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_hold%0d: got gnt=%b err=%b expected 0010 0", k, t.gnt, t.timeout_err);
            end
            tick;
        end
        vectors++;
        if ({t.gnt, t.busy, t.timeout_err} !== {4'b0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_abort: got %b expected %b", {t.gnt, t.busy, t.timeout_err}, {4'b0000, 1'b0, 1'b1});
        end
        for (int k = 0; k < 2; k++) begin
            t.req = 4'b0001;
            tick;
            t.req = 4'b0000;
            vectors++;
            if ({t.sel, t.busy, t.timeout_err} !== {2'b00, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL timeout_sticky_busy%0d: got %b expected %b", k, {t.sel, t.busy, t.timeout_err}, 4'b0011);
            end
            t.mem_done = 1'b1;
            tick;
            t.mem_done = 1'b0;
            vectors++;
            if ({t.busy, t.timeout_err} !== 2'b01) begin
                miscompares++;
                $display("FAIL timeout_sticky_idle%0d: got %b expected 01", k, {t.busy, t.timeout_err});
            end
        end
    endtask

    task automatic test_hold_drop;
        apply_reset;
        a.req = 4'b0010;
        tick;
        a.req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({a.sel, a.gnt, a.busy} !== {2'b01, 4'b0010, 1'b1}) begin
                miscompares++;
                $display("FAIL hold%0d: got %b expected %b", k, {a.sel, a.gnt, a.busy}, {2'b01, 4'b0010, 1'b1});
            end
            tick;
        end
        a.mem_done = 1'b1;
        tick;
        vectors++;
        if ({a.gnt, a.busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL hold_release: got %b expected 00000", {a.gnt, a.busy});
        end
        tick;
        a.mem_done = 1'b0;
        vectors++;
        if ({a.sel, a.gnt, a.mem_start, a.busy} !== {2'b01, 4'b0000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_done_ignored: got %b expected %b", {a.sel, a.gnt, a.mem_start, a.busy}, {2'b01, 6'b0});
        end
    endtask

    task automatic test_async_reset;
        apply_reset;
        a.req = 4'b1000;
        tick;
        a.req = 4'b0000;
        tick;
        vectors++;
        if (a.gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL areset_pre: got %b expected 1000", a.gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({a.sel, a.gnt, a.busy, a.mem_start} !== 8'b0) begin
            miscompares++;
            $display("FAIL areset_immediate: got %b expected 00000000", {a.sel, a.gnt, a.busy, a.mem_start});
        end
        a.req = 4'b1000;
        tick;
        vectors++;
        if ({a.gnt, a.mem_start} !== 5'b0) begin
            miscompares++;
            $display("FAIL areset_held: got %b expected 00000", {a.gnt, a.mem_start});
        end
        rst_n = 1'b1;
        tick;
        a.req = 4'b0000;
        vectors++;
        if ({a.sel, a.gnt, a.mem_start} !== {2'b11, 4'b1000, 1'b1}) begin
            miscompares++;
            $display("FAIL areset_regrant: got %b expected %b", {a.sel, a.gnt, a.mem_start}, {2'b11, 4'b1000, 1'b1});
        end
        a.mem_done = 1'b1;
        tick;
        a.mem_done = 1'b0;
    endtask

    initial begin
        a.req = 4'b0000;
        a.mem_done = 1'b0;
        t.req = 4'b0000;
        t.mem_done = 1'b0;
        test_reset;
        test_single;
        test_rotation;
        test_wrap;
        test_timeout;
        test_hold_drop;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
